// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory (combinational read, synchronous
//   write) between the CPU data port (master 0) and a debug/DMA loader
//   (master 1). One master owns the memory per cycle. A consecutive-grant
//   counter limits how long one master can keep the memory while the other
//   waits, so neither starves.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   m0_*               CPU data port: req/we/addr/wdata in, rdata/stall out
//   m1_*               loader port:   req/we/addr/wdata in, rdata/gnt out
//   mem_*              data memory side: we/addr/wdata out, rdata in
//   owner_q            id of the last granted master
//   burst_cnt_q        consecutive grants to owner_q, saturating at 7
module dmem_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_stall,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner_q,
   output logic [2:0]        burst_cnt_q
);

   logic grant0;
   logic grant1;
   logic burst_full;

   assign burst_full = ({29'd0, burst_cnt_q} >= MAX_BURST);

   // Grants are forced low during reset so no write can leak to memory and
   // neither master sees a stall or grant while the arbiter is held in reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         if (m0_req && !m1_req) begin
            grant0 = 1'b1;
         end else if (m1_req && !m0_req) begin
            grant1 = 1'b1;
         end else if (m0_req && m1_req) begin
            // Incumbent keeps the memory until its run reaches MAX_BURST.
            if (!burst_full) begin
               grant0 = ~owner_q;
               grant1 = owner_q;
            end else begin
               grant0 = owner_q;
               grant1 = ~owner_q;
            end
         end
      end
   end

   // With no grant the address/data default to master 0 but the write is
   // suppressed.
   always_comb begin
      if (grant1) begin
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_we    = m1_we;
      end else begin
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_we    = grant0 & m0_we;
      end
   end

   assign m0_rdata = mem_rdata;
   assign m1_rdata = mem_rdata;
   assign m0_stall = rst_n & m0_req & ~grant0;
   assign m1_gnt   = grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= 1'b0;
         burst_cnt_q <= '0;
      end else if (grant0 || grant1) begin
         if (grant1 == owner_q) begin
            if (burst_cnt_q != 3'd7) begin
               burst_cnt_q <= burst_cnt_q + 3'd1;
            end
         end else begin
            owner_q     <= grant1;
            burst_cnt_q <= 3'd1;
         end
      end else begin
         burst_cnt_q <= '0;
      end
   end

endmodule
